// File: rtl/me_sad_mv_select.sv
// Minimum-SAD / motion-vector selector for one CTU search.
// Tracks the best (lowest) SAD and its motion vector per sub-block (CB 0..3)
// while the PE array streams tagged SAD samples, then drains the four winners
// downstream over a valid/ready handshake.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   begin_prepare         start (or restart) a CTU search, clears trackers
//   sad_valid/sad_cb/sad_value/search_column_count/search_row_count
//                         tagged SAD sample input
//   search_done           pulse: last sample of the CTU presented
//   result_valid/ready    result handshake
//   result_cb/hit/sad/mv_x/mv_y  per-CB best candidate
//   busy                  state is not IDLE
//   search_finished       pulse after the CB3 result is accepted
module me_sad_mv_select #(
  parameter int unsigned SAD_W      = 16,
  parameter int unsigned COL_CENTER = 12,
  parameter int unsigned ROW_CENTER = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             begin_prepare,
  input  logic             sad_valid,
  input  logic [1:0]       sad_cb,
  input  logic [SAD_W-1:0] sad_value,
  input  logic [4:0]       search_column_count,
  input  logic [6:0]       search_row_count,
  input  logic             search_done,
  input  logic             result_ready,
  output logic             result_valid,
  output logic [1:0]       result_cb,
  output logic             result_hit,
  output logic [SAD_W-1:0] result_sad,
  output logic [5:0]       result_mv_x,
  output logic [7:0]       result_mv_y,
  output logic             busy,
  output logic             search_finished
);

  localparam int unsigned NUM_CB = 4;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, FINISH} state_t;

  state_t           state;
  logic [1:0]       idx;
  logic [1:0]       idx_inc;

  logic [SAD_W-1:0] best_sad [NUM_CB];
  logic [NUM_CB-1:0] hit;
  logic [5:0]       mv_x [NUM_CB];
  logic [7:0]       mv_y [NUM_CB];

  logic [SAD_W-1:0] nxt_sad [NUM_CB];
  logic [NUM_CB-1:0] nxt_hit;
  logic [5:0]       nxt_mv_x [NUM_CB];
  logic [7:0]       nxt_mv_y [NUM_CB];

  logic [5:0]       sample_mv_x;
  logic [7:0]       sample_mv_y;

  assign idx_inc     = 2'(idx + 2'd1);
  assign sample_mv_x = 6'({1'b0, search_column_count} - 6'(COL_CENTER));
  assign sample_mv_y = 8'({1'b0, search_row_count} - 8'(ROW_CENTER));

  // Next tracker contents; the drain loads from these so a sample arriving
  // together with search_done is already reflected in the first result.
  always_comb begin
    nxt_hit = hit;
    for (int i = 0; i < NUM_CB; i++) begin
      nxt_sad[i]  = best_sad[i];
      nxt_mv_x[i] = mv_x[i];
      nxt_mv_y[i] = mv_y[i];
    end
    if ((state == IDLE || state == COLLECT) && begin_prepare) begin
      nxt_hit = '0;
      for (int i = 0; i < NUM_CB; i++) begin
        nxt_sad[i]  = '1;
        nxt_mv_x[i] = '0;
        nxt_mv_y[i] = '0;
      end
    end else if (state == COLLECT && sad_valid &&
                 (!hit[sad_cb] || sad_value < best_sad[sad_cb])) begin
      // Strict compare: ties keep the earlier sample.
      nxt_hit[sad_cb]  = 1'b1;
      nxt_sad[sad_cb]  = sad_value;
      nxt_mv_x[sad_cb] = sample_mv_x;
      nxt_mv_y[sad_cb] = sample_mv_y;
    end
  end

  // Control FSM, tracker registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      idx             <= '0;
      hit             <= '0;
      for (int i = 0; i < NUM_CB; i++) begin
        best_sad[i] <= '1;
        mv_x[i]     <= '0;
        mv_y[i]     <= '0;
      end
      result_valid    <= 1'b0;
      result_cb       <= '0;
      result_hit      <= 1'b0;
      result_sad      <= '0;
      result_mv_x     <= '0;
      result_mv_y     <= '0;
      busy            <= 1'b0;
      search_finished <= 1'b0;
    end else begin
      hit <= nxt_hit;
      for (int i = 0; i < NUM_CB; i++) begin
        best_sad[i] <= nxt_sad[i];
        mv_x[i]     <= nxt_mv_x[i];
        mv_y[i]     <= nxt_mv_y[i];
      end
      search_finished <= 1'b0;

      case (state)
        IDLE: begin
          if (begin_prepare) begin
            state <= COLLECT;
            busy  <= 1'b1;
          end
        end
        COLLECT: begin
          if (!begin_prepare && search_done) begin
            state        <= DRAIN;
            idx          <= 2'd0;
            result_valid <= 1'b1;
            result_cb    <= 2'd0;
            result_hit   <= nxt_hit[0];
            result_sad   <= nxt_sad[0];
            result_mv_x  <= nxt_mv_x[0];
            result_mv_y  <= nxt_mv_y[0];
          end
        end
        DRAIN: begin
          if (result_ready) begin
            if (idx == 2'd3) begin
              state           <= FINISH;
              result_valid    <= 1'b0;
              search_finished <= 1'b1;
            end else begin
              idx         <= idx_inc;
              result_cb   <= idx_inc;
              result_hit  <= nxt_hit[idx_inc];
              result_sad  <= nxt_sad[idx_inc];
              result_mv_x <= nxt_mv_x[idx_inc];
              result_mv_y <= nxt_mv_y[idx_inc];
            end
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_me_sad_mv_select.sv
// Self-checking bench for me_sad_mv_select: directed scenarios plus randomized
// searches checked against a per-CB minimum computed from the sample list.
module tb_me_sad_mv_select;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        begin_prepare;
  logic        sad_valid;
  logic [1:0]  sad_cb;
  logic [15:0] sad_value;
  logic [4:0]  search_column_count;
  logic [6:0]  search_row_count;
  logic        search_done;
  logic        result_ready;
  logic        result_valid;
  logic [1:0]  result_cb;
  logic        result_hit;
  logic [15:0] result_sad;
  logic [5:0]  result_mv_x;
  logic [7:0]  result_mv_y;
  logic        busy;
  logic        search_finished;

  me_sad_mv_select #(.SAD_W(16), .COL_CENTER(12), .ROW_CENTER(32)) dut (
    .clk(clk), .rst_n(rst_n), .begin_prepare(begin_prepare),
    .sad_valid(sad_valid), .sad_cb(sad_cb), .sad_value(sad_value),
    .search_column_count(search_column_count), .search_row_count(search_row_count),
    .search_done(search_done), .result_ready(result_ready),
    .result_valid(result_valid), .result_cb(result_cb), .result_hit(result_hit),
    .result_sad(result_sad), .result_mv_x(result_mv_x), .result_mv_y(result_mv_y),
    .busy(busy), .search_finished(search_finished)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {int cb; int sad; int col; int row;} sample_t;
  sample_t samples[$];

  int e_hit[4];
  int e_sad[4];
  int e_mvx[4];
  int e_mvy[4];

  logic [32:0] cap_vec[8];
  int cap_n, stall_changes, fin_cnt, fin_cyc, first_valid, last_acc, timeout;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected per-CB winner: minimum SAD, earliest sample among equal minima.
  task automatic model_expect();
    for (int c = 0; c < 4; c++) begin
      int minsad;
      minsad   = -1;
      e_hit[c] = 0; e_sad[c] = 65535; e_mvx[c] = 0; e_mvy[c] = 0;
      foreach (samples[k])
        if (samples[k].cb == c && (minsad < 0 || samples[k].sad < minsad)) minsad = samples[k].sad;
      if (minsad >= 0) begin
        for (int k = 0; k < samples.size(); k++) begin
          if (samples[k].cb == c && samples[k].sad == minsad) begin
            e_hit[c] = 1; e_sad[c] = minsad;
            e_mvx[c] = samples[k].col - 12; e_mvy[c] = samples[k].row - 32;
            break;
          end
        end
      end
    end
  endtask

  task automatic start();
    begin_prepare = 1'b1;
    samples.delete();
    step();
    begin_prepare = 1'b0;
  endtask

  task automatic send(input int cb, input int sad, input int c, input int r, input bit done);
    sample_t s;
    s = '{cb, sad, c, r};
    sad_valid = 1'b1; sad_cb = 2'(cb); sad_value = 16'(sad);
    search_column_count = 5'(c); search_row_count = 7'(r); search_done = done;
    samples.push_back(s);
    step();
    sad_valid = 1'b0; search_done = 1'b0;
  endtask

  task automatic done_only();
    search_done = 1'b1;
    step();
    search_done = 1'b0;
  endtask

  // Drives result_ready and records accepted results and handshake timing.
  task automatic drain_capture(input int stall_cb, input int stall_len, input bit rnd);
    logic [32:0] cur, prev;
    bit prev_stall;
    int stalls;
    cap_n = 0; stall_changes = 0; fin_cnt = 0; fin_cyc = -1;
    first_valid = -1; last_acc = -1; timeout = 1; stalls = 0;
    prev_stall = 0; prev = '0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      cur = {result_cb, result_hit, result_sad, result_mv_x, result_mv_y};
      if (search_finished) begin fin_cnt++; fin_cyc = cyc; end
      if (fin_cnt > 0 && !busy) begin timeout = 0; break; end
      if (result_valid && first_valid < 0) first_valid = cyc;
      if (result_valid && int'(result_cb) == stall_cb && stalls < stall_len) begin
        result_ready = 1'b0; stalls++;
      end else begin
        result_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (result_valid && prev_stall && cur !== prev) stall_changes++;
      prev_stall = result_valid && !result_ready;
      prev = cur;
      if (result_valid && result_ready) begin
        if (cap_n < 8) cap_vec[cap_n] = cur;
        cap_n++; last_acc = cyc;
      end
      step();
    end
    result_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      begin_prepare = 1'($urandom); sad_valid = 1'($urandom); sad_cb = 2'($urandom);
      sad_value = 16'($urandom); search_column_count = 5'($urandom);
      search_row_count = 7'($urandom); search_done = 1'($urandom); result_ready = 1'($urandom);
      step();
    end
    n_checks++;
    if ({result_valid, result_cb, result_hit, result_sad, result_mv_x, result_mv_y,
         busy, search_finished} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%0b cb=%0d hit=%0b sad=%h busy=%0b fin=%0b, want all 0",
               result_valid, result_cb, result_hit, result_sad, busy, search_finished);
    end
    begin_prepare = 0; sad_valid = 0; search_done = 0; result_ready = 0;
    rst_n = 1'b1;
    step();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %0b want 0", busy); end
    start();
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_prepare: got %0b want 1", busy); end
  endtask

  task automatic test_basic();
    start();
    send(0, 100, 12, 32, 0);
    send(0, 40, 13, 30, 0);
    send(0, 40, 5, 40, 0);
    done_only();
    n_checks++;
    if (result_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency: valid=%0b want 1", result_valid); end
    drain_capture(-1, 0, 0);
    model_expect();
    n_checks++;
    if (cap_n !== 4) begin n_fail++; $display("FAIL basic_count: got %0d want 4", cap_n); end
    for (int i = 0; i < 4 && i < cap_n; i++) begin
      n_checks++;
      if (cap_vec[i] !== {2'(i), 1'(e_hit[i]), 16'(e_sad[i]), 6'(e_mvx[i]), 8'(e_mvy[i])}) begin
        n_fail++; $display("FAIL basic_result%0d: got %h want %h", i, cap_vec[i],
                           {2'(i), 1'(e_hit[i]), 16'(e_sad[i]), 6'(e_mvx[i]), 8'(e_mvy[i])});
      end
    end
    n_checks++;
    if (cap_vec[0] !== {2'd0, 1'b1, 16'd40, 6'd1, 8'hFE}) begin
      n_fail++; $display("FAIL basic_cb0_const: got %h want %h", cap_vec[0], {2'd0, 1'b1, 16'd40, 6'd1, 8'hFE});
    end
    n_checks++;
    if (cap_vec[3] !== {2'd3, 1'b0, 16'hFFFF, 6'd0, 8'd0}) begin
      n_fail++; $display("FAIL basic_cb3_empty: got %h want %h", cap_vec[3], {2'd3, 1'b0, 16'hFFFF, 6'd0, 8'd0});
    end
    n_checks++;
    if (fin_cnt !== 1 || fin_cyc - first_valid !== 4 || timeout !== 0) begin
      n_fail++; $display("FAIL basic_finish: pulses=%0d delay=%0d timeout=%0d want 1/4/0",
                         fin_cnt, fin_cyc - first_valid, timeout);
    end
  endtask

  task automatic test_final_cycle();
    start();
    send(1, 50, 3, 3, 0);
    send(2, 7, 0, 0, 1);
    n_checks++;
    if (result_valid !== 1'b1) begin n_fail++; $display("FAIL final_latency: valid=%0b want 1", result_valid); end
    drain_capture(-1, 0, 0);
    model_expect();
    for (int i = 0; i < 4 && i < cap_n; i++) begin
      n_checks++;
      if (cap_vec[i] !== {2'(i), 1'(e_hit[i]), 16'(e_sad[i]), 6'(e_mvx[i]), 8'(e_mvy[i])}) begin
        n_fail++; $display("FAIL final_result%0d: got %h want %h", i, cap_vec[i],
                           {2'(i), 1'(e_hit[i]), 16'(e_sad[i]), 6'(e_mvx[i]), 8'(e_mvy[i])});
      end
    end
    n_checks++;
    if (cap_n !== 4 || cap_vec[2] !== {2'd2, 1'b1, 16'd7, 6'h34, 8'hE0}) begin
      n_fail++; $display("FAIL final_cb2_const: n=%0d got %h want %h", cap_n, cap_vec[2],
                         {2'd2, 1'b1, 16'd7, 6'h34, 8'hE0});
    end
  endtask

  task automatic test_backpressure();
    start();
    for (int k = 0; k < 12; k++)
      send(int'($urandom_range(0, 3)), int'($urandom_range(0, 200)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 127)), 0);
    done_only();
    drain_capture(1, 3, 0);
    model_expect();
    n_checks++;
    if (cap_n !== 4 || stall_changes !== 0) begin
      n_fail++; $display("FAIL bp_hold: accepted=%0d changes=%0d want 4/0", cap_n, stall_changes);
    end
    for (int i = 0; i < 4 && i < cap_n; i++) begin
      n_checks++;
      if (cap_vec[i] !== {2'(i), 1'(e_hit[i]), 16'(e_sad[i]), 6'(e_mvx[i]), 8'(e_mvy[i])}) begin
        n_fail++; $display("FAIL bp_result%0d: got %h want %h", i, cap_vec[i],
                           {2'(i), 1'(e_hit[i]), 16'(e_sad[i]), 6'(e_mvx[i]), 8'(e_mvy[i])});
      end
    end
    n_checks++;
    if (fin_cnt !== 1 || fin_cyc - last_acc !== 1) begin
      n_fail++; $display("FAIL bp_finish: pulses=%0d delay=%0d want 1/1", fin_cnt, fin_cyc - last_acc);
    end
  endtask

  task automatic test_restart();
    start();
    send(0, 5, 1, 1, 0);
    // Restart with a competing sample and search_done in the same cycle.
    begin_prepare = 1'b1; sad_valid = 1'b1; sad_cb = 2'd0; sad_value = 16'd1;
    search_column_count = 5'd2; search_row_count = 7'd2; search_done = 1'b1;
    samples.delete();
    step();
    begin_prepare = 1'b0; sad_valid = 1'b0; search_done = 1'b0;
    n_checks++;
    if (result_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL restart_priority: valid=%0b busy=%0b want 0/1", result_valid, busy);
    end
    send(0, 9, 20, 20, 0);
    done_only();
    drain_capture(-1, 0, 0);
    model_expect();
    n_checks++;
    if (cap_n !== 4 || cap_vec[0] !== {2'd0, 1'b1, 16'd9, 6'(20 - 12), 8'(20 - 32)}) begin
      n_fail++; $display("FAIL restart_cb0: n=%0d got %h want %h", cap_n, cap_vec[0],
                         {2'd0, 1'b1, 16'd9, 6'(20 - 12), 8'(20 - 32)});
    end
    // IDLE ignores samples and search_done.
    sad_valid = 1'b1; sad_cb = 2'd0; sad_value = 16'd0; search_done = 1'b1;
    step();
    sad_valid = 1'b0; search_done = 1'b0;
    step();
    n_checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_ignore: valid=%0b busy=%0b want 0/0", result_valid, busy);
    end
  endtask

  task automatic test_reset_drain();
    int fins;
    start();
    for (int k = 0; k < 8; k++)
      send(int'($urandom_range(0, 3)), int'($urandom_range(0, 99)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 127)), 0);
    done_only();
    result_ready = 1'b1;
    step();
    step();
    result_ready = 1'b0;
    n_checks++;
    if (result_valid !== 1'b1 || result_cb !== 2'd2) begin
      n_fail++; $display("FAIL rd_at_cb2: valid=%0b cb=%0d want 1/2", result_valid, result_cb);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rd_reset: valid=%0b busy=%0b want 0/0", result_valid, busy);
    end
    fins = 0;
    for (int i = 0; i < 5; i++) begin
      if (search_finished) fins++;
      step();
    end
    n_checks++;
    if (fins !== 0) begin n_fail++; $display("FAIL rd_no_finish: pulses=%0d want 0", fins); end
    start();
    done_only();
    drain_capture(-1, 0, 0);
    model_expect();
    for (int i = 0; i < 4 && i < cap_n; i++) begin
      n_checks++;
      if (cap_vec[i] !== {2'(i), 1'b0, 16'hFFFF, 6'd0, 8'd0}) begin
        n_fail++; $display("FAIL rd_empty%0d: got %h want %h", i, cap_vec[i], {2'(i), 1'b0, 16'hFFFF, 6'd0, 8'd0});
      end
    end
    n_checks++;
    if (cap_n !== 4) begin n_fail++; $display("FAIL rd_count: got %0d want 4", cap_n); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      int n;
      n = int'($urandom_range(0, 30));
      start();
      for (int k = 0; k < n; k++)
        send(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 31)), int'($urandom_range(0, 127)), (k == n - 1) && (t % 2 == 0));
      if (n == 0 || t % 2 != 0) done_only();
      drain_capture(-1, 0, 1);
      model_expect();
      n_checks++;
      if (cap_n !== 4 || stall_changes !== 0 || fin_cnt !== 1 || timeout !== 0) begin
        n_fail++; $display("FAIL rand%0d_flow: n=%0d changes=%0d pulses=%0d timeout=%0d",
                           t, cap_n, stall_changes, fin_cnt, timeout);
      end
      for (int i = 0; i < 4 && i < cap_n; i++) begin
        n_checks++;
        if (cap_vec[i] !== {2'(i), 1'(e_hit[i]), 16'(e_sad[i]), 6'(e_mvx[i]), 8'(e_mvy[i])}) begin
          n_fail++; $display("FAIL rand%0d_result%0d: got %h want %h", t, i, cap_vec[i],
                             {2'(i), 1'(e_hit[i]), 16'(e_sad[i]), 6'(e_mvx[i]), 8'(e_mvy[i])});
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; begin_prepare = 0; sad_valid = 0; sad_cb = 0; sad_value = 0;
    search_column_count = 0; search_row_count = 0; search_done = 0; result_ready = 0;
    test_reset();
    test_basic();
    test_final_cycle();
    test_backpressure();
    test_restart();
    test_reset_drain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/me_sad_mv_select.md
Name: me_sad_mv_select

Overview:
- Receiving end of the PE array control/SAD stream in the DMT motion-estimation datapath.
- Consumes SAD results tagged with the search position and sub-block (CB) index that the array controller drives.
- Tracks the minimum SAD and its motion vector separately for each of the 4 CBs over one CTU search.
- When the search ends, hands the 4 best candidates downstream over a valid/ready handshake.

Parameters:
- SAD_W, 16: width of the SAD value.
- COL_CENTER, 12: search column count that maps to mv_x = 0.
- ROW_CENTER, 32: search row count that maps to mv_y = 0.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- begin_prepare  in  1  start of a new CTU search; clears all trackers.
- sad_valid  in  1  sad_value/tags valid this cycle.
- sad_cb  in  2  CB index 0..3 of the sample.
- sad_value  in  SAD_W  SAD of the sample.
- search_column_count  in  5  column tag of the sample.
- search_row_count  in  7  row tag of the sample.
- search_done  in  1  one-cycle pulse: last sample of the CTU has been (or is being) presented.
- result_ready  in  1  downstream accepts the current result.
- result_valid  out  1  result_* fields valid.
- result_cb  out  2  CB index of the result.
- result_hit  out  1  at least one sample was seen for this CB.
- result_sad  out  SAD_W  minimum SAD.
- result_mv_x  out  6  signed mv_x = column − COL_CENTER.
- result_mv_y  out  8  signed mv_y = row − ROW_CENTER.
- busy  out  1  state is not IDLE.
- search_finished  out  1  one-cycle pulse after the CB3 result is accepted.

Behaviour:
- Clock and reset:
  - One clock domain. All state updates on the posedge clk.
  - rst_n low at an edge forces: state = IDLE; all outputs 0; trackers cleared (best_sad all-ones, hit = 0, mv = 0).
- States: IDLE, COLLECT, DRAIN, FINISH.
- IDLE:
  - sad_valid and search_done are ignored.
  - begin_prepare=1 → clear trackers, go to COLLECT next cycle; busy = 1 from that cycle.
- COLLECT:
  - sad_valid=1: update the tracker of CB sad_cb if hit == 0 or sad_value < best_sad (strict compare). The update stores the sad, column and row, and sets hit.
  - Ties keep the earlier sample. The tracker update is visible one cycle later.
  - mv arithmetic: mv_x = {1'b0, column} − COL_CENTER, truncated to 6 bits two's complement; mv_y = {1'b0, row} − ROW_CENTER, truncated to 8 bits.
  - search_done=1 → go to DRAIN with result index 0. A sad_valid in the same cycle is still applied before draining.
  - begin_prepare=1 while in COLLECT restarts: trackers cleared, stay in COLLECT. begin_prepare takes priority over search_done and sad_valid in the same cycle.
- DRAIN:
  - result_valid = 1; result_cb = index; result_* show that CB's tracker.
  - Fields hold stable while result_ready = 0.
  - On result_valid & result_ready: index + 1. At index 3, go to FINISH and drop result_valid.
  - Back-to-back acceptance drains the 4 results in 4 cycles.
  - sad_valid, search_done and begin_prepare are ignored.
  - A CB with no samples drains with hit = 0, sad = all-ones, mv = 0.
- FINISH:
  - search_finished = 1 for exactly one cycle, then IDLE with busy = 0.
  - Latency: search_done edge → first result_valid = 1 cycle. Last acceptance → search_finished = 1 cycle.
- Trackers are not cleared on return to IDLE; they are cleared only by begin_prepare or reset.
- Reset mid-DRAIN: result_valid drops at the reset edge and no search_finished is issued.

Test Plan:
- Reset with all inputs toggling → every output 0, busy = 0. Assert begin_prepare → busy = 1 on the next cycle.
- Basic search: CB0 samples (col 12, row 32, sad 100), (col 13, row 30, sad 40), (col 5, row 40, sad 40); search_done; result_ready = 1 → CB0: sad 40, mv_x = 1, mv_y = −2, hit = 1. Other CBs: hit = 0, sad 0xFFFF. search_finished 4 cycles after the first result_valid.
- Final-cycle sample: a sample on the same cycle as search_done (CB2, sad 7, col 0, row 0) → CB2 reports sad 7, mv_x = −12, mv_y = −32.
- Backpressure: result_ready low for 3 cycles at CB1 → result_cb stays 1 with stable fields; no skip or duplicate; CB order 0, 1, 2, 3.
- Restart: begin_prepare mid-COLLECT after a CB0 sad of 5, then a CB0 sad of 9 → CB0 reports 9. In IDLE, a sample with sad_valid=1 and no begin_prepare → ignored.
- Reset mid-DRAIN at CB2 → result_valid = 0, no search_finished. A new begin_prepare → all CBs start with hit = 0.
